fe_pow: RTL and testbench
=========================

Name: fe_pow

Overview:
- Parametrised field exponentiation engine: computes result = base^e mod p by left-to-right square-and-multiply.
- Generalises the fixed p-2 inversion loop at the end of the scalar-multiplication core. Width, exponent length and the built-in exponent are parameters, and a mode selects an arbitrary or fixed exponent.
- Owns no multiplier. It drives a shared external femul-style port, so the ladder core and fe_pow can time-share one femul through an arbiter.

Parameters:
WIDTH, 255, field element width in bits.
EXP_BITS, 255, exponent width; scan runs from bit EXP_BITS-1 down to 0.
INV_EXP, (2^255)-21, EXP_BITS-wide fixed exponent used when mode=1 (p-2 gives inversion).

Ports:
clock     in   1         rising-edge clock
reset     in   1         asynchronous, active-high reset
start     in   1         request; sampled only when busy=0
mode      in   1         0: exponent from port; 1: INV_EXP
base      in   WIDTH     base operand, captured on accepted start
exponent  in   EXP_BITS  exponent, captured on accepted start (ignored when mode=1)
busy      out  1         high from cycle after accepted start until done rises
done      out  1         level; high while result valid, cleared on next accepted start
result    out  WIDTH     final value; held until next accepted start
mul_start out  1         one-cycle request pulse to multiplier
mul_a     out  WIDTH     multiplier operand A, stable from mul_start until mul_done
mul_b     out  WIDTH     multiplier operand B, same stability rule
mul_done  in   1         one-cycle pulse; mul_out valid that cycle
mul_out   in   WIDTH     multiplier product (reduced mod p by the multiplier)

Behaviour:
- Reset, asynchronous:
  - State=IDLE; busy=0, done=0, mul_start=0.
  - result=0, mul_a=0, mul_b=0, acc=1, bit index=EXP_BITS-1.
- Accepted start (start=1 and busy=0, including while done=1):
  - Latch base into b_reg; latch e_reg = mode ? INV_EXP : exponent.
  - acc<=1; idx<=EXP_BITS-1; done<=0; busy<=1; state<=SQR.
- start while busy=1: ignored, no effect on any register.
- SQR: issue mul_start with mul_a=mul_b=acc. On mul_done, acc<=mul_out, then:
  - if e_reg[idx]=1: go to MUL;
  - else if idx=0: finish;
  - else: idx<=idx-1 and stay in SQR.
- MUL: issue mul_start with mul_a=acc, mul_b=b_reg. On mul_done, acc<=mul_out, then:
  - if idx=0: finish;
  - else: idx<=idx-1 and go to SQR.
- Finish: result<=mul_out; done<=1; busy<=0; state<=IDLE. All in the cycle after the final mul_done.
- Issue timing:
  - mul_start is a registered pulse, exactly one cycle wide.
  - First request goes out the cycle after the accepted start; each later request goes out the cycle after the previous mul_done.
  - Never more than one request outstanding.
- mul_done while no request is outstanding (including in IDLE): ignored.
- Latency, with L = multiplier cycles from mul_start to mul_done and N = multiplications issued:
  - done rises N*(L+1)+1 cycles after the accepted-start edge.
  - Non-constant-time: N = EXP_BITS + popcount(e).
- exponent=0 gives result=1 for any base, including base=0.
- Widths: acc, b_reg and result are WIDTH bits. No reduction inside fe_pow; operands are forwarded unchanged.
- Reset mid-operation: immediate abort to reset values. A mul_done arriving later is ignored; the bench drains the multiplier.

Optional Feature:
- Macro FE_POW_CONST_TIME_EN.
- Defined:
  - MUL runs for every bit. mul_b=b_reg when e_reg[idx]=1, otherwise mul_b=1 with the product still written to acc (acc*1).
  - N = 2*EXP_BITS for every exponent; done timing and the mul_start pattern are exponent-independent.
- Undefined: MUL is skipped for zero bits, as in Behaviour.

Test Plan:
- Bench setup: behavioural multiplier with L=3, product mod p=2^255-19; default parameters.
- mode=0, base=3, exponent=5 -> result=243; without CT, 257 mul_start pulses; done at cycle 257*4+1=1029.
- mode=1, base=2 -> result=(p+1)/2; result*2 mod p=1.
- mode=0, exponent=0, base=0 -> result=1; base=7, exponent=1 -> result=7.
- Second start with new operands while busy -> ignored; first result unchanged; busy profile unchanged. A start after done -> done drops next cycle.
- reset asserted after the 10th mul_done -> busy, done, mul_start and result all 0 the same cycle; a late mul_done is ignored; a fresh start then gives 3^5=243.
- With FE_POW_CONST_TIME_EN defined: exponent=0 and exponent=2^255-1 both give done at cycle 510*4+1=2041, with identical mul_start timing.

Source files
------------

// File: rtl/fe_pow_if.sv
// fe_pow_if: bundles the fe_pow request/result handshake and the shared
// femul-style multiplier port into one interface.
// slave  : the fe_pow engine side (takes requests, drives the multiplier).
// master : the environment side (issues requests, returns products).
interface fe_pow_if #(
   parameter int WIDTH    = 255,
   parameter int EXP_BITS = 255
);

   // Request / result handshake
   logic                start;
   logic                mode;
   logic [WIDTH-1:0]    base;
   logic [EXP_BITS-1:0] exponent;
   logic                busy;
   logic                done;
   logic [WIDTH-1:0]    result;

   // Shared multiplier port
   logic                mul_start;
   logic [WIDTH-1:0]    mul_a;
   logic [WIDTH-1:0]    mul_b;
   logic                mul_done;
   logic [WIDTH-1:0]    mul_out;

   modport slave (
      input  start,
      input  mode,
      input  base,
      input  exponent,
      output busy,
      output done,
      output result,
      output mul_start,
      output mul_a,
      output mul_b,
      input  mul_done,
      input  mul_out
   );

   modport master (
      output start,
      output mode,
      output base,
      output exponent,
      input  busy,
      input  done,
      input  result,
      input  mul_start,
      input  mul_a,
      input  mul_b,
      output mul_done,
      output mul_out
   );

endinterface

// File: rtl/fe_pow.sv
// fe_pow: field exponentiation result = base^e mod p by left-to-right
// square-and-multiply. Owns no multiplier; every product is requested over
// the shared femul-style port in fe_pow_if, one request outstanding at most.
// mode=0 takes the exponent from the port, mode=1 uses INV_EXP (p-2 gives
// the field inverse).
// Optional feature macro: FE_POW_CONST_TIME_EN -- when defined, the multiply
// step runs for every exponent bit (multiplying by 1 for zero bits) so the
// request pattern and completion time do not depend on the exponent.
module fe_pow #(
   parameter int                  WIDTH    = 255,
   parameter int                  EXP_BITS = 255,
   // 2^255 - 21 for the default width: all ones except bits 4 and 2
   parameter logic [EXP_BITS-1:0] INV_EXP  = {{(EXP_BITS-5){1'b1}}, 5'b01011}
) (
   input  logic     clock,
   input  logic     reset,
   fe_pow_if.slave  bus
);

   localparam int               IDX_W   = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_BITS - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQR  = 2'd1,
      MUL  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                wait_q, wait_d;       // a multiplier request is outstanding
   logic                mul_start_q, mul_start_d;
   logic [WIDTH-1:0]    mul_a_q, mul_a_d;
   logic [WIDTH-1:0]    mul_b_q, mul_b_d;
   logic [WIDTH-1:0]    acc_q, acc_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0]    result_q, result_d;
   logic [WIDTH-1:0]    b_q, b_d;
   logic [EXP_BITS-1:0] e_q, e_d;

   logic                e_bit;
   logic                go_mul;

   // Operand B of the multiply step: the base for a one bit, otherwise 1 so
   // the product leaves the accumulator unchanged (only reached in the
   // constant-time build, the variable-time build skips zero bits).
   function automatic logic [WIDTH-1:0] mul_operand(input logic          bit_set,
                                                    input logic [WIDTH-1:0] base_val);
      return bit_set ? base_val : ONE;
   endfunction

   assign e_bit = e_q[idx_q];

   // Next-state, request issue and result capture
   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      done_d      = done_q;
      wait_d      = wait_q;
      mul_start_d = 1'b0;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      result_d    = result_q;
      b_d         = b_q;
      e_d         = e_q;
      go_mul      = 1'b0;

      unique case (state_q)
         IDLE: begin
            // start is only looked at here; busy is low exactly in IDLE
            if (bus.start) begin
               b_d     = bus.base;
               e_d     = bus.mode ? INV_EXP : bus.exponent;
               acc_d   = ONE;
               idx_d   = IDX_TOP;
               done_d  = 1'b0;
               busy_d  = 1'b1;
               wait_d  = 1'b0;
               state_d = SQR;
            end
         end

         SQR: begin
            if (!wait_q) begin
               // First request of an operation: square the initial acc
               mul_start_d = 1'b1;
               mul_a_d     = acc_q;
               mul_b_d     = acc_q;
               wait_d      = 1'b1;
            end else if (bus.mul_done) begin
               acc_d = bus.mul_out;
`ifdef FE_POW_CONST_TIME_EN
               go_mul = 1'b1;
`else
               go_mul = e_bit;
`endif
               if (go_mul) begin
                  // Multiply the fresh square by the base (or by 1)
                  state_d     = MUL;
                  mul_start_d = 1'b1;
                  mul_a_d     = bus.mul_out;
                  mul_b_d     = mul_operand(e_bit, b_q);
               end else if (idx_q == '0) begin
                  result_d = bus.mul_out;
                  done_d   = 1'b1;
                  busy_d   = 1'b0;
                  wait_d   = 1'b0;
                  state_d  = IDLE;
               end else begin
                  // Zero bit: next square issues straight from the product
                  idx_d       = idx_q - IDX_W'(1);
                  mul_start_d = 1'b1;
                  mul_a_d     = bus.mul_out;
                  mul_b_d     = bus.mul_out;
               end
            end
         end

         MUL: begin
            if (bus.mul_done) begin
               acc_d = bus.mul_out;
               if (idx_q == '0) begin
                  result_d = bus.mul_out;
                  done_d   = 1'b1;
                  busy_d   = 1'b0;
                  wait_d   = 1'b0;
                  state_d  = IDLE;
               end else begin
                  idx_d       = idx_q - IDX_W'(1);
                  state_d     = SQR;
                  mul_start_d = 1'b1;
                  mul_a_d     = bus.mul_out;
                  mul_b_d     = bus.mul_out;
               end
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            wait_d  = 1'b0;
         end
      endcase
   end

   // Control and accumulator state; reset aborts any operation immediately
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wait_q      <= 1'b0;
         mul_start_q <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         acc_q       <= ONE;
         idx_q       <= IDX_TOP;
         result_q    <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         wait_q      <= wait_d;
         mul_start_q <= mul_start_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         result_q    <= result_d;
      end
   end

   // Operand latches; only meaningful after an accepted start
   always_ff @(posedge clock) begin
      b_q <= b_d;
      e_q <= e_d;
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.result    = result_q;
   assign bus.mul_start = mul_start_q;
   assign bus.mul_a     = mul_a_q;
   assign bus.mul_b     = mul_b_q;

endmodule

// File: tb/tb_fe_pow.sv
// tb_fe_pow: directed bench for fe_pow with a behavioural mod-p multiplier
// (latency 3, p = 2^255 - 19).
module tb_fe_pow;

   localparam int W  = 255;
   localparam int EB = 255;
   localparam int L  = 3;
   localparam logic [255:0] P    = (256'd1 << 255) - 256'd19;
   localparam logic [255:0] HALF = (P + 256'd1) >> 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   fe_pow_if #(.WIDTH(W), .EXP_BITS(EB)) bus ();

   fe_pow #(.WIDTH(W), .EXP_BITS(EB)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Behavioural multiplier: product reduced mod p, mul_done L cycles after mul_start
   function automatic logic [W-1:0] modmul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [511:0] pr;
      pr = {257'd0, a} * {257'd0, b};
      return W'(pr % {256'd0, P});
   endfunction

   int           mcnt  = 0;
   logic         mbusy = 1'b0;
   logic [W-1:0] mprod = '0;

   always @(posedge clk) begin
      if (bus.mul_start === 1'b1) begin
         mbusy        <= 1'b1;
         mcnt         <= L - 1;
         mprod        <= modmul(bus.mul_a, bus.mul_b);
         bus.mul_done <= 1'b0;
      end else if (mbusy && mcnt == 1) begin
         bus.mul_done <= 1'b1;
         bus.mul_out  <= mprod;
         mbusy        <= 1'b0;
      end else begin
         bus.mul_done <= 1'b0;
         if (mbusy) mcnt <= mcnt - 1;
      end
   end

   // Cycle counter plus request/response tallies
   longint tick  = 0;
   longint npul  = 0;
   longint psum  = 0;
   longint ndone = 0;

   always @(posedge clk) begin
      tick <= tick + 1;
      if (bus.mul_start === 1'b1) begin
         npul <= npul + 1;
         psum <= psum + tick;
      end
      if (bus.mul_done === 1'b1) ndone <= ndone + 1;
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int n_of(input logic [EB-1:0] e);
`ifdef FE_POW_CONST_TIME_EN
      return 2 * EB;
`else
      return EB + $countones(e);
`endif
   endfunction

   // One operation: start, optionally poke a start while busy, wait for done
   task automatic run(input logic m, input logic [W-1:0] b, input logic [EB-1:0] e,
                      input int poke, input bit prev_done,
                      output logic [W-1:0] res, output int cyc,
                      output longint np, output longint sig);
      longint n0, s0, t0;
      bit     bok;
      @(negedge clk);
      if (prev_done) chk("pre_start_done", 256'(bus.done), 256'd1);
      bus.mode     = m;
      bus.base     = b;
      bus.exponent = e;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      n0 = npul;
      s0 = psum;
      t0 = tick;
      chk("accept_done_low", 256'(bus.done), 256'd0);
      chk("accept_busy", 256'(bus.busy), 256'd1);
      cyc = 0;
      bok = 1'b1;
      while (bus.done !== 1'b1 && cyc < 6000) begin
         if (cyc == poke) begin
            bus.start    = 1'b1;
            bus.base     = 255'd9;
            bus.exponent = 255'd3;
            bus.mode     = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk);
         #1;
         cyc++;
         if (bus.done !== 1'b1 && bus.busy !== 1'b1) bok = 1'b0;
      end
      bus.start = 1'b0;
      chk("done_seen", 256'(bus.done), 256'd1);
      chk("busy_profile", 256'(bok), 256'd1);
      chk("busy_low_at_done", 256'(bus.busy), 256'd0);
      res = bus.result;
      np  = npul - n0;
      sig = (psum - s0) - np * t0;
   endtask

   initial begin
      logic [W-1:0]  res;
      logic [EB-1:0] ones;
      int            cyc, cyc_a, k;
      longint        np, sig, sig_a, d0;

      ones         = '1;
      bus.start    = 1'b0;
      bus.mode     = 1'b0;
      bus.base     = '0;
      bus.exponent = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 256'(bus.busy), 256'd0);
      chk("rst_done", 256'(bus.done), 256'd0);
      chk("rst_mul_start", 256'(bus.mul_start), 256'd0);
      chk("rst_result", 256'(bus.result), 256'd0);
      chk("rst_mul_a", 256'(bus.mul_a), 256'd0);
      chk("rst_mul_b", 256'(bus.mul_b), 256'd0);
      @(negedge clk);
      rst = 1'b0;

      // 3^5
      run(1'b0, 255'd3, 255'd5, -1, 1'b0, res, cyc, np, sig);
      chk("pow3_5_res", 256'(res), 256'd243);
      chk("pow3_5_cyc", 256'(cyc), 256'(n_of(255'd5) * (L + 1) + 1));
      chk("pow3_5_pulses", 256'(np), 256'(n_of(255'd5)));

      // Inversion of 2 via the built-in exponent
      run(1'b1, 255'd2, 255'd77, -1, 1'b1, res, cyc, np, sig);
      chk("inv2_res", 256'(res), HALF);
      chk("inv2_times2", (256'(res) << 1) % P, 256'd1);
      chk("inv2_cyc", 256'(cyc), 256'(n_of({{(EB-5){1'b1}}, 5'b01011}) * (L + 1) + 1));

      // Zero exponent with zero base, then exponent one
      run(1'b0, 255'd0, 255'd0, -1, 1'b1, res, cyc, np, sig);
      chk("pow0_0_res", 256'(res), 256'd1);
      chk("pow0_0_cyc", 256'(cyc), 256'(n_of(255'd0) * (L + 1) + 1));
      run(1'b0, 255'd7, 255'd1, -1, 1'b1, res, cyc, np, sig);
      chk("pow7_1_res", 256'(res), 256'd7);
      chk("pow7_1_pulses", 256'(np), 256'(n_of(255'd1)));

      // Start with other operands while busy must be ignored
      run(1'b0, 255'd3, 255'd5, 100, 1'b1, res, cyc, np, sig);
      chk("busy_poke_res", 256'(res), 256'd243);
      chk("busy_poke_cyc", 256'(cyc), 256'(n_of(255'd5) * (L + 1) + 1));
      chk("busy_poke_pulses", 256'(np), 256'(n_of(255'd5)));

      // Timing for extreme exponents
      run(1'b0, 255'd5, 255'd0, -1, 1'b1, res, cyc_a, np, sig_a);
      chk("e0_res", 256'(res), 256'd1);
      chk("e0_cyc", 256'(cyc_a), 256'(n_of(255'd0) * (L + 1) + 1));
      run(1'b0, 255'd5, ones, -1, 1'b1, res, cyc, np, sig);
      chk("eall_cyc", 256'(cyc), 256'(n_of(ones) * (L + 1) + 1));
      chk("eall_pulses", 256'(np), 256'(n_of(ones)));
`ifdef FE_POW_CONST_TIME_EN
      chk("ct_same_cyc", 256'(cyc), 256'(cyc_a));
      chk("ct_same_pattern", 256'(sig), 256'(sig_a));
`endif

      // Reset mid-operation after the 10th product
      @(negedge clk);
      bus.mode     = 1'b0;
      bus.base     = 255'd3;
      bus.exponent = 255'd5;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      d0 = ndone;
      k  = 0;
      while (ndone - d0 < 10 && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("mid_reach10", 256'(ndone - d0), 256'd10);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 256'(bus.busy), 256'd0);
      chk("mid_rst_done", 256'(bus.done), 256'd0);
      chk("mid_rst_mul_start", 256'(bus.mul_start), 256'd0);
      chk("mid_rst_result", 256'(bus.result), 256'd0);
      @(negedge clk);
      rst = 1'b0;
      d0  = ndone;
      repeat (8) @(posedge clk);
      #1;
      chk("late_done_seen", 256'(ndone - d0), 256'd1);
      chk("late_busy", 256'(bus.busy), 256'd0);
      chk("late_done", 256'(bus.done), 256'd0);
      chk("late_mul_start", 256'(bus.mul_start), 256'd0);
      chk("late_result", 256'(bus.result), 256'd0);

      // Fresh operation after the abort
      run(1'b0, 255'd3, 255'd5, -1, 1'b0, res, cyc, np, sig);
      chk("post_rst_res", 256'(res), 256'd243);
      chk("post_rst_cyc", 256'(cyc), 256'(n_of(255'd5) * (L + 1) + 1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
